// File: rtl/alu_pkg.sv
// Shared definitions for the ALU service unit: opcode and SET-variant codes,
// plus the response record carried through the response FIFO.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SET  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_NAND = 4'd13;

    localparam logic [2:0] SET_SLT = 3'd0;
    localparam logic [2:0] SET_SGT = 3'd1;
    localparam logic [2:0] SET_SLE = 3'd2;
    localparam logic [2:0] SET_SGE = 3'd3;
    localparam logic [2:0] SET_SNE = 3'd4;
    localparam logic [2:0] SET_SEQ = 3'd6;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  zero;
        logic                  cout;
        logic                  overflow;
        logic                  illegal;
    } alu_rsp_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: request fields in, complete response record out.
module alu_core
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] i_src1,
    input  logic [ALU_DATA_W-1:0] i_src2,
    input  logic [3:0]            i_alu_control,
    input  logic [2:0]            i_bonus_control,
    output alu_rsp_t              o_rsp
);

    localparam int MSB = ALU_DATA_W - 1;

    // One extra bit on both adders so the carry out falls out naturally;
    // subtraction is done as A + ~B + 1 so its carry means "no borrow".
    logic [ALU_DATA_W:0] w_add;
    logic [ALU_DATA_W:0] w_sub;
    logic                w_lt;
    logic                w_eq;
    logic                w_set_cond;
    logic                w_set_legal;
    logic                w_legal;

    assign w_add = {1'b0, i_src1} + {1'b0, i_src2};
    assign w_sub = {1'b0, i_src1} + {1'b0, ~i_src2} + {{ALU_DATA_W{1'b0}}, 1'b1};
    assign w_lt  = $signed(i_src1) < $signed(i_src2);
    assign w_eq  = (i_src1 == i_src2);

    // Select the SET condition; codes 5 and 7 have no meaning.
    always_comb begin
        w_set_cond  = 1'b0;
        w_set_legal = 1'b1;
        case (i_bonus_control)
            SET_SLT: w_set_cond = w_lt;
            SET_SGT: w_set_cond = !w_lt && !w_eq;
            SET_SLE: w_set_cond = w_lt || w_eq;
            SET_SGE: w_set_cond = !w_lt;
            SET_SNE: w_set_cond = !w_eq;
            SET_SEQ: w_set_cond = w_eq;
            default: w_set_legal = 1'b0;
        endcase
    end

    // Build the response; illegal requests collapse to a fixed zero result.
    always_comb begin
        o_rsp   = '0;
        w_legal = 1'b1;
        case (i_alu_control)
            OP_AND:  o_rsp.result = i_src1 & i_src2;
            OP_OR:   o_rsp.result = i_src1 | i_src2;
            OP_NOR:  o_rsp.result = ~(i_src1 | i_src2);
            OP_NAND: o_rsp.result = ~(i_src1 & i_src2);
            OP_ADD: begin
                o_rsp.result   = w_add[MSB:0];
                o_rsp.cout     = w_add[ALU_DATA_W];
                o_rsp.overflow = (i_src1[MSB] == i_src2[MSB]) && (w_add[MSB] != i_src1[MSB]);
            end
            OP_SUB: begin
                o_rsp.result   = w_sub[MSB:0];
                o_rsp.cout     = w_sub[ALU_DATA_W];
                o_rsp.overflow = (i_src1[MSB] != i_src2[MSB]) && (w_sub[MSB] != i_src1[MSB]);
            end
            OP_SET: begin
                o_rsp.result = {{(ALU_DATA_W-1){1'b0}}, w_set_cond};
                w_legal      = w_set_legal;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            o_rsp         = '0;
            o_rsp.illegal = 1'b1;
        end
        o_rsp.zero = (o_rsp.result == '0);
    end

endmodule

// File: rtl/alu_service_unit.sv
// ALU service unit: valid/ready request in, ALU result out through a
// 2-entry response FIFO, with a count of consumed responses.
module alu_service_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,   // must equal ALU_DATA_W (record width)
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [3:0]        ALU_control,
    input  logic [2:0]        bonus_control,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              cout,
    output logic              overflow,
    output logic              illegal,
    output logic [CNT_W-1:0]  done_count
);

    alu_rsp_t         w_core_rsp;
    alu_rsp_t         w_out;
    alu_rsp_t         r_mem [2];
    alu_rsp_t         r_last;
    logic [1:0]       r_count;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_done;
    logic             w_push;
    logic             w_pop;

    alu_core u_core (
        .i_src1          (src1),
        .i_src2          (src2),
        .i_alu_control   (ALU_control),
        .i_bonus_control (bonus_control),
        .o_rsp           (w_core_rsp)
    );

    // Ready depends only on the registered fill level, never on rsp_ready,
    // so no combinational path runs from the consumer back to the producer.
    assign req_ready = rst_n && (r_count != 2'd2);
    assign rsp_valid = (r_count != 2'd0);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    // Head of the FIFO when valid, otherwise the last consumed response.
    assign w_out      = rsp_valid ? r_mem[r_rd_ptr] : r_last;
    assign result     = w_out.result;
    assign zero       = w_out.zero;
    assign cout       = w_out.cout;
    assign overflow   = w_out.overflow;
    assign illegal    = w_out.illegal;
    assign done_count = r_done;

    // Storage slots; contents only matter while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_core_rsp;
        end
    end

    // Pointers, fill level, last-popped record and consumed-response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_last   <= '0;
            r_done   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
                r_last   <= r_mem[r_rd_ptr];
                r_done   <= r_done + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_service_unit.sv
// Self-checking bench for alu_service_unit: directed steps followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_alu_service_unit;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        cout;
        logic        ov;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ALU_control;
    logic [2:0]  bonus_control;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;
    logic        illegal;
    logic [15:0] done_count;

    int          n_cmp;
    int          n_fail;
    exp_t        exp_q[$];
    exp_t        last_exp;
    logic [15:0] done_exp;

    alu_service_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .src1          (src1),
        .src2          (src2),
        .ALU_control   (ALU_control),
        .bonus_control (bonus_control),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .result        (result),
        .zero          (zero),
        .cout          (cout),
        .overflow      (overflow),
        .illegal       (illegal),
        .done_count    (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference ALU from the arithmetic definitions, using wide signed and
    // unsigned integers instead of bit-level carry logic.
    function automatic exp_t ref_alu(input logic [3:0] op, input logic [2:0] bo,
                                     input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        bit              legal;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned us;
        longint          sa;
        longint          sb;
        longint          ss;
        int              t;
        e     = '0;
        legal = 1;
        ua    = a;
        ub    = b;
        sa    = $signed(a);
        sb    = $signed(b);
        case (op)
            4'd0:  e.result = a & b;
            4'd1:  e.result = a | b;
            4'd12: e.result = ~(a | b);
            4'd13: e.result = ~(a & b);
            4'd2: begin
                us       = ua + ub;
                e.result = us[31:0];
                e.cout   = (us >= 64'h1_0000_0000);
                ss       = sa + sb;
                t        = int'(ss);
                e.ov     = (longint'(t) != ss);
            end
            4'd6: begin
                e.result = a - b;
                e.cout   = (ua >= ub);
                ss       = sa - sb;
                t        = int'(ss);
                e.ov     = (longint'(t) != ss);
            end
            4'd7: begin
                case (bo)
                    3'd0: e.result = {31'd0, sa <  sb};
                    3'd1: e.result = {31'd0, sa >  sb};
                    3'd2: e.result = {31'd0, sa <= sb};
                    3'd3: e.result = {31'd0, sa >= sb};
                    3'd4: e.result = {31'd0, sa != sb};
                    3'd6: e.result = {31'd0, sa == sb};
                    default: legal = 0;
                endcase
            end
            default: legal = 0;
        endcase
        if (!legal) begin
            e     = '0;
            e.ill = 1'b1;
        end
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    // One clock cycle: check visible state against the model, then advance
    // the model by what the handshake does at the coming rising edge.
    task automatic tick(output bit pushed);
        exp_t want;
        exp_t nxt;
        bit   m_ready;
        bit   m_pop;
        #1;
        m_ready = rst_n && (exp_q.size() < 2);
        m_pop   = (exp_q.size() != 0) && rsp_ready;
        want    = (exp_q.size() != 0) ? exp_q[0] : last_exp;
        nxt     = ref_alu(ALU_control, bonus_control, src1, src2);
        cmp("req_ready", req_ready, m_ready);
        cmp("rsp_valid", rsp_valid, exp_q.size() != 0);
        cmp("result", result, want.result);
        cmp("flags_zcvi", {zero, cout, overflow, illegal}, {want.zero, want.cout, want.ov, want.ill});
        cmp("done_count", done_count, done_exp);
        pushed = req_valid && m_ready;
        @(posedge clk);
        if (m_pop) begin
            last_exp = exp_q.pop_front();
            done_exp = done_exp + 16'd1;
            $display("rsp %0d: result=%h zcvi=%b%b%b%b", done_exp, last_exp.result,
                     last_exp.zero, last_exp.cout, last_exp.ov, last_exp.ill);
        end
        if (pushed) exp_q.push_back(nxt);
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] bo,
                        input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc           = 0;
        req_valid     = 1'b1;
        ALU_control   = op;
        bonus_control = bo;
        src1          = a;
        src2          = b;
        for (int k = 0; k < 20 && !acc; k++) tick(acc);
        cmp("send_accepted", acc, 1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick(acc);
        cmp("drained", exp_q.size(), 0);
    endtask

    initial begin
        bit          acc;
        logic [2:0]  set_codes [6];
        logic        set_exp   [6];
        logic [3:0]  op_list   [9];
        logic [31:0] edge_vals [5];
        logic [15:0] base;

        set_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        set_exp   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        op_list   = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13, 4'd4, 4'd15};
        edge_vals = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1};

        n_cmp = 0; n_fail = 0;
        last_exp = '0; done_exp = '0;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        src1 = '0; src2 = '0; ALU_control = '0; bonus_control = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        cmp("rst_req_ready", req_ready, 0);
        cmp("rst_rsp_valid", rsp_valid, 0);
        cmp("rst_result", result, 0);
        cmp("rst_flags", {zero, cout, overflow, illegal}, 4'b0000);
        cmp("rst_done", done_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD overflow case
        rsp_ready = 1'b1;
        send(4'd2, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        #1;
        cmp("add_valid", rsp_valid, 1);
        cmp("add_result", result, 32'h8000_0000);
        cmp("add_zcv", {zero, cout, overflow}, 3'b001);
        tick(acc);
        #1;
        cmp("add_done", done_count, 16'd1);

        // Two SUBs back to back
        send(4'd6, 3'd0, 32'd5, 32'd5);
        #1;
        cmp("sub0_result", result, 32'd0);
        cmp("sub0_zcv", {zero, cout, overflow}, 3'b110);
        send(4'd6, 3'd0, 32'd0, 32'd1);
        #1;
        cmp("sub1_valid", rsp_valid, 1);
        cmp("sub1_result", result, 32'hFFFF_FFFF);
        cmp("sub1_zcv", {zero, cout, overflow}, 3'b000);
        drain();

        // SET variants with -2 vs 3
        for (int i = 0; i < 6; i++) begin
            send(4'd7, set_codes[i], 32'hFFFF_FFFE, 32'h0000_0003);
            #1;
            cmp("set_result", result, {31'd0, set_exp[i]});
            cmp("set_cv", {cout, overflow}, 2'b00);
        end
        drain();

        // Back-pressure with three NANDs
        base          = done_exp;
        rsp_ready     = 1'b0;
        req_valid     = 1'b1;
        ALU_control   = 4'd13;
        bonus_control = 3'd0;
        src1          = 32'hFFFF_FFFF;
        src2          = 32'hFFFF_FFFF;
        tick(acc);
        cmp("bp_acc0", acc, 1);
        tick(acc);
        cmp("bp_acc1", acc, 1);
        #1;
        cmp("bp_full_ready", req_ready, 0);
        tick(acc);
        cmp("bp_acc2_blocked", acc, 0);
        rsp_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 10 && !acc; k++) tick(acc);
        cmp("bp_acc2", acc, 1);
        req_valid = 1'b0;
        drain();
        #1;
        cmp("bp_result", result, 32'd0);
        cmp("bp_done", done_count, base + 16'd3);

        // Illegal opcode and illegal SET code
        send(4'd4, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        #1;
        cmp("ill_op_result", result, 32'd0);
        cmp("ill_op_zi", {zero, illegal}, 2'b11);
        send(4'd7, 3'd5, 32'h1, 32'h2);
        #1;
        cmp("ill_set_result", result, 32'd0);
        cmp("ill_set_zi", {zero, illegal}, 2'b11);
        drain();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            req_valid     = ($urandom_range(0, 3) != 0);
            rsp_ready     = ($urandom_range(0, 2) != 0);
            ALU_control   = op_list[$urandom_range(0, 8)];
            bonus_control = 3'($urandom_range(0, 7));
            src1          = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            src2          = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            tick(acc);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Asynchronous reset while the FIFO is full
        rsp_ready = 1'b0;
        send(4'd2, 3'd0, 32'd10, 32'd20);
        send(4'd0, 3'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("arst_rsp_valid", rsp_valid, 0);
        cmp("arst_req_ready", req_ready, 0);
        cmp("arst_done", done_count, 0);
        cmp("arst_result", result, 0);
        cmp("arst_flags", {zero, cout, overflow, illegal}, 4'b0000);
        exp_q.delete();
        last_exp = '0;
        done_exp = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        send(4'd1, 3'd0, 32'hF0F0_0000, 32'h0000_F0F0);
        #1;
        cmp("post_rst_or", result, 32'hF0F0_F0F0);
        tick(acc);
        #1;
        cmp("post_rst_done", done_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_service_unit.md
Name: alu_service_unit

Overview:
- Sequential responder for the ALU operation stream that the lab01 pattern driver issues.
- Accepts one operation per cycle on a valid/ready request channel and computes the result with the lab01 ALU semantics.
- Returns result plus zero/cout/overflow flags on a valid/ready response channel, buffered in a 2-entry response FIFO.
- Sits between a pattern source (bench or on-chip sequencer) and a checker; tolerates back-pressure on both sides.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- src1  input  DATA_W  operand A.
- src2  input  DATA_W  operand B.
- ALU_control  input  4  opcode: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SET, 12 NOR, 13 NAND.
- bonus_control  input  3  SET variant: 0 SLT, 1 SGT, 2 SLE, 3 SGE, 4 SNE, 6 SEQ.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- result  output  DATA_W  computed result.
- zero  output  1  result == 0.
- cout  output  1  carry out (ADD/SUB only).
- overflow  output  1  signed overflow (ADD/SUB only).
- illegal  output  1  opcode, or SET bonus code, is undefined.
- done_count  output  CNT_W  number of responses consumed.

Behaviour:
- Reset (rst_n low, any time, mid-transfer included): FIFO emptied; rsp_valid=0, req_ready=0 while rst_n low, result=0, zero/cout/overflow/illegal=0, done_count=0. In-flight requests are discarded.
- Request accept: at a clk edge with req_valid && req_ready.
- req_ready = rst_n && (fifo_count < 2).
  - Derived from registered count only.
  - No combinational path from rsp_ready to req_ready.
- Compute: combinational on the request inputs; the result is written into the FIFO at the accept edge.
- Latency: request accepted at edge N into an empty FIFO gives rsp_valid=1 after edge N. Full throughput of 1/cycle when rsp_ready is held high.
- Response pop: at an edge with rsp_valid && rsp_ready. done_count increments, wrapping at 2^CNT_W-1 -> 0.
- Simultaneous push and pop:
  - fifo_count unchanged.
  - Order preserved (FIFO, head on outputs).
  - Allowed while count==1. At count==2, req_ready=0, so no push occurs.
- Response outputs are held stable while rsp_valid && !rsp_ready.
- Outputs are don't-care-free: when the FIFO is empty they show the last popped entry (0 after reset).
- Arithmetic:
  - ADD: s = src1 + src2. cout = bit DATA_W. overflow = (a_msb == b_msb) && (s_msb != a_msb).
  - SUB: s = src1 + ~src2 + 1. cout = carry out (1 iff src1 >= src2 unsigned). overflow = (a_msb != b_msb) && (s_msb != a_msb).
  - AND/OR/NOR/NAND: bitwise.
  - SET: result = {31'b0, cond}, with signed comparison of src1 vs src2.
  - cout and overflow are 0 for every op other than ADD and SUB.
  - zero is always (result == 0).
- Illegal cases: undefined ALU_control, or ALU_control==7 with bonus_control in {5,7}.
  - result = 0, zero = 1, cout = 0, overflow = 0, illegal = 1.
  - Still consumes a FIFO slot and a response.

Decomposition:
- Shared package alu_pkg:
  - opcode constants: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SET, OP_NOR, OP_NAND.
  - bonus constants: SET_SLT, SET_SGT, SET_SLE, SET_SGE, SET_SNE, SET_SEQ.
  - response record (result, zero, cout, overflow, illegal).
- Sub-module alu_core: purely combinational compute (request fields -> response record).
- alu_service_unit: handshake, 2-entry FIFO with pointers and count, and the done_count counter.

Test Plan:
- Reset, then one ADD with 0x7FFFFFFF + 0x00000001, rsp_ready=1 -> next cycle: result=0x80000000, zero=0, cout=0, overflow=1, done_count=1.
- SUB with 5 - 5, then SUB with 0x00000000 - 0x00000001:
  - first response: result=0, zcv=110.
  - second response: result=0xFFFFFFFF, zcv=000.
  - responses arrive back-to-back on consecutive cycles.
- SET sequence with src1=0xFFFFFFFE (-2), src2=0x00000003, bonus 0,1,2,3,4,6 -> results 1,0,1,0,1,0; cout and overflow always 0.
- Back-pressure: rsp_ready=0, issue 3 NAND requests -> first two accepted, then req_ready=0. Raise rsp_ready -> responses in order, 0x00000000 for src=0xFFFFFFFF/0xFFFFFFFF, done_count=3 at the end.
- Illegal input: ALU_control=4, and ALU_control=7 with bonus=5 -> result=0, zero=1, illegal=1 for both.
- Reset mid-operation: hold rsp_ready=0, fill the FIFO, pulse rst_n low asynchronously between edges -> rsp_valid=0 and done_count=0 immediately. After release, one fresh OR of 0xF0F00000 | 0x0000F0F0 -> 0xF0F0F0F0.
